rb_ctx: RTL and testbench



---
 rtl/rb_ctx.sv | 152 +++++++++++++++
 tb/tb_rb_ctx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rb_ctx.sv
// rb_ctx: user/hidden register bank with one write port, two combinational
// read ports, optional write-to-read forwarding, and a sequential context
// engine that copies the whole user bank to the hidden bank (save) or back
// (restore), one register per cycle, with a busy/done handshake.
//
// Address map: the MSB of an address selects the hidden bank and the low
// bits give the register index. With NREG a power of two this makes the
// flat storage index equal to the address itself. AW is expected to keep
// its default value.
module rb_ctx #(
    parameter int DW     = 16,
    parameter int NREG   = 8,
    parameter int AW     = $clog2(2*NREG),
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] d_in,
    input  logic          rw_in,
    input  logic [AW-1:0] wa_in,
    input  logic [AW-1:0] ra_a_in,
    input  logic [AW-1:0] ra_b_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    input  logic          save_req_in,
    input  logic          restore_req_in,
    output logic          busy_out,
    output logic          done_out
);

    localparam int IW   = $clog2(NREG);
    localparam int NTOT = 2 * NREG;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_RESTORE,
        ST_DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic          busy_q;
    logic          busy_d;
    logic          done_q;
    logic          done_d;
    logic          last_idx;
    logic          wr_en;
    logic [AW-1:0] usr_addr;
    logic [AW-1:0] hid_addr;

    logic [DW-1:0] regs_q [NTOT];

    // The write port is only honoured while the context engine is not copying.
    assign wr_en    = rw_in && !busy_q;
    assign last_idx = (idx_q == IW'(NREG - 1));
    assign usr_addr = {1'b0, idx_q};
    assign hid_addr = {1'b1, idx_q};

    assign busy_out = busy_q;
    assign done_out = done_q;

    // State register for the context engine plus its registered handshake outputs.
    // NOTE: every clocked assignment uses <= so all flops sample pre-edge values
    // together; a blocking = here would let later statements see updated values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, copy index and next handshake values.
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                // Save wins when both requests arrive together.
                if (save_req_in) begin
                    state_d = ST_SAVE;
                end else if (restore_req_in) begin
                    state_d = ST_RESTORE;
                end
            end
            ST_SAVE, ST_RESTORE: begin
                if (last_idx) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                // Requests seen during the done cycle are deliberately dropped.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_SAVE) || (state_d == ST_RESTORE);
        done_d = (state_d == ST_DONE);
    end

    // Register storage: copy engine has priority; otherwise the write port updates.
    // NOTE: the storage array is reset on purpose, because a cleared bank is
    // architecturally visible after reset; that forces it into flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTOT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == ST_SAVE) begin
            regs_q[hid_addr] <= regs_q[usr_addr];
        end else if (state_q == ST_RESTORE) begin
            regs_q[usr_addr] <= regs_q[hid_addr];
        end else if (wr_en) begin
            regs_q[wa_in] <= d_in;
        end
    end

    // Read port A: storage, optionally replaced by same-cycle write data.
    always_comb begin
        a_out = regs_q[ra_a_in];
        if (BYPASS && wr_en && (ra_a_in == wa_in)) begin
            a_out = d_in;
        end
    end

    // Read port B: storage, optionally replaced by same-cycle write data.
    always_comb begin
        b_out = regs_q[ra_b_in];
        if (BYPASS && wr_en && (ra_b_in == wa_in)) begin
            b_out = d_in;
        end
    end

endmodule

// File: tb/tb_rb_ctx.sv
// tb_rb_ctx: directed and random stimulus for rb_ctx, with two instances
// (forwarding on and off) driven in parallel and compared against a
// behavioural model that tracks the copy by edge offsets from acceptance.
module tb_rb_ctx;

    localparam int DW   = 16;
    localparam int NREG = 8;
    localparam int AW   = $clog2(2*NREG);
    localparam int NA   = 2 * NREG;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] d_in;
    logic          rw_in;
    logic [AW-1:0] wa_in;
    logic [AW-1:0] ra_a_in;
    logic [AW-1:0] ra_b_in;
    logic          save_req_in;
    logic          restore_req_in;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic          busy_out;
    logic          done_out;
    logic [DW-1:0] a_nb;
    logic [DW-1:0] b_nb;
    logic          busy_nb;
    logic          done_nb;

    rb_ctx #(.DW(DW), .NREG(NREG), .AW(AW), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .rw_in(rw_in), .wa_in(wa_in),
        .ra_a_in(ra_a_in), .ra_b_in(ra_b_in), .a_out(a_out), .b_out(b_out),
        .save_req_in(save_req_in), .restore_req_in(restore_req_in),
        .busy_out(busy_out), .done_out(done_out)
    );

    rb_ctx #(.DW(DW), .NREG(NREG), .AW(AW), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .rw_in(rw_in), .wa_in(wa_in),
        .ra_a_in(ra_a_in), .ra_b_in(ra_b_in), .a_out(a_nb), .b_out(b_nb),
        .save_req_in(save_req_in), .restore_req_in(restore_req_in),
        .busy_out(busy_nb), .done_out(done_nb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt;

    // Behavioural model: bank contents plus the edge at which the last copy was accepted.
    logic [DW-1:0] mdl_mem [NA];
    int            edge_n;
    int            acc_edge;
    bit            acc_valid;
    bit            acc_save;

    function automatic void mdl_reset();
        for (int i = 0; i < NA; i++) mdl_mem[i] = '0;
        acc_valid = 1'b0;
        acc_edge  = 0;
        acc_save  = 1'b0;
    endfunction

    // Busy for the NREG cycles following the accepting edge, done in the one after.
    function automatic bit mdl_busy();
        return acc_valid && ((edge_n - acc_edge) < NREG);
    endfunction

    function automatic bit mdl_done();
        return acc_valid && ((edge_n - acc_edge) == NREG);
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] addr, input bit byp);
        if (byp && rw_in && !mdl_busy() && (addr == wa_in)) return d_in;
        return mdl_mem[int'(addr)];
    endfunction

    // Apply one rising edge to the model using the inputs as they stand at the edge.
    task automatic mdl_edge();
        int e;
        int k;
        bit was_busy;
        bit was_done;
        e = edge_n + 1;
        if (!rst_n) begin
            mdl_reset();
        end else begin
            was_busy = mdl_busy();
            was_done = mdl_done();
            if (was_busy) begin
                k = e - acc_edge - 1;
                if (acc_save) mdl_mem[NREG + k] = mdl_mem[k];
                else          mdl_mem[k]        = mdl_mem[NREG + k];
            end else begin
                if (rw_in) mdl_mem[int'(wa_in)] = d_in;
                if (!was_done && (save_req_in || restore_req_in)) begin
                    acc_valid = 1'b1;
                    acc_edge  = e;
                    acc_save  = save_req_in;
                end
            end
        end
        edge_n = e;
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_edge();
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_ctrl(input string tag);
        chk_bit({tag, ".busy"},    busy_out, mdl_busy());
        chk_bit({tag, ".done"},    done_out, mdl_done());
        chk_bit({tag, ".busy_nb"}, busy_nb,  mdl_busy());
        chk_bit({tag, ".done_nb"}, done_nb,  mdl_done());
    endtask

    task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b);
        ra_a_in = a;
        ra_b_in = b;
        #1;
        chk({tag, ".a"},    a_out, exp_rd(a, 1'b1));
        chk({tag, ".b"},    b_out, exp_rd(b, 1'b1));
        chk({tag, ".a_nb"}, a_nb,  exp_rd(a, 1'b0));
        chk({tag, ".b_nb"}, b_nb,  exp_rd(b, 1'b0));
    endtask

    task automatic write_reg(input int addr, input logic [DW-1:0] val);
        rw_in = 1'b1;
        wa_in = AW'(addr);
        d_in  = val;
        tick();
        rw_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; d_in = '0; rw_in = 1'b0; wa_in = '0; ra_a_in = '0; ra_b_in = '0;
        save_req_in = 1'b0; restore_req_in = 1'b0;
        edge_n = 0;
        mdl_reset();
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset state: every address reads zero, engine idle.
        check_ctrl("reset");
        for (int i = 0; i < NREG; i++) begin
            rd_check("reset_rd", AW'(i), AW'(i + NREG));
            chk("reset_zero_a", a_out, 16'h0000);
            chk("reset_zero_b", b_out, 16'h0000);
            tick();
        end

        // Forwarding: visible in the write cycle only with forwarding enabled.
        rw_in = 1'b1; wa_in = AW'(3); d_in = 16'h1234;
        rd_check("byp_wr", AW'(3), AW'(5));
        chk("byp_on", a_out, 16'h1234);
        chk("byp_off", a_nb, 16'h0000);
        tick();
        rw_in = 1'b0;
        rd_check("byp_next", AW'(3), AW'(3));
        chk("byp_off_next", a_nb, 16'h1234);

        // Save: load user bank, busy for NREG cycles, done pulse after.
        for (int i = 0; i < NREG; i++) write_reg(i, DW'(32'h0010 + i));
        save_req_in = 1'b1;
        tick();
        save_req_in = 1'b0;
        for (int c = 0; c < NREG; c++) begin
            rd_check("save_rd", AW'(c), AW'(c + NREG));
            check_ctrl("save");
            chk_bit("save_busy", busy_out, 1'b1);
            tick();
        end
        check_ctrl("save_done");
        chk_bit("save_done_pulse", done_out, 1'b1);
        chk_bit("save_done_busy", busy_out, 1'b0);
        tick();
        check_ctrl("save_after");
        for (int i = 0; i < NREG; i++) begin
            rd_check("save_hid", AW'(NREG + i), AW'(i));
            chk("save_hid_val", a_out, DW'(32'h0010 + i));
            tick();
        end

        // Restore over a clobbered user bank; a mid-restore write is dropped.
        for (int i = 0; i < NREG; i++) write_reg(i, 16'hFFFF);
        restore_req_in = 1'b1;
        tick();
        restore_req_in = 1'b0;
        for (int c = 0; c < NREG; c++) begin
            if (c == 3) begin
                rw_in = 1'b1; wa_in = AW'(2); d_in = 16'hAAAA;
            end else begin
                rw_in = 1'b0;
            end
            rd_check("rest_rd", AW'(2), AW'(c));
            check_ctrl("restore");
            tick();
        end
        rw_in = 1'b0;
        check_ctrl("rest_done");
        chk_bit("rest_done_pulse", done_out, 1'b1);
        tick();
        for (int i = 0; i < NREG; i++) begin
            rd_check("rest_val", AW'(i), AW'(NREG + i));
            chk("rest_user", a_out, DW'(32'h0010 + i));
            tick();
        end
        rd_check("rest_r2", AW'(2), AW'(2));
        chk("rest_r2_dropped", a_out, 16'h0012);

        // Simultaneous requests perform a save; a request while busy is dropped.
        for (int i = 0; i < NREG; i++) write_reg(i, DW'(32'h0100 + i));
        save_req_in = 1'b1; restore_req_in = 1'b1;
        tick();
        save_req_in = 1'b0; restore_req_in = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < NREG + 4; c++) begin
            save_req_in = (c == 2);
            check_ctrl("both");
            if (done_out) done_cnt++;
            tick();
        end
        save_req_in = 1'b0;
        chk("single_done", DW'(done_cnt), DW'(1));
        for (int i = 0; i < NREG; i++) begin
            rd_check("both_hid", AW'(NREG + i), AW'(i));
            chk("both_saved", a_out, DW'(32'h0100 + i));
            tick();
        end

        // Reset in the fourth busy cycle of a save abandons it with no done pulse.
        for (int i = 0; i < NREG; i++) write_reg(i, DW'($urandom));
        save_req_in = 1'b1;
        tick();
        save_req_in = 1'b0;
        repeat (3) begin
            check_ctrl("pre_rst");
            tick();
        end
        rst_n = 1'b0;
        mdl_reset();
        #1;
        check_ctrl("rst_mid");
        chk_bit("rst_busy_low", busy_out, 1'b0);
        for (int i = 0; i < NREG; i++) begin
            rd_check("rst_rd", AW'(i), AW'(NREG + i));
            chk("rst_zero_a", a_out, 16'h0000);
            chk("rst_zero_b", b_out, 16'h0000);
            tick();
        end
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < NREG + 4; c++) begin
            check_ctrl("post_rst");
            if (done_out) done_cnt++;
            tick();
        end
        chk("no_done_after_rst", DW'(done_cnt), DW'(0));

        // A fresh save after reset completes normally.
        for (int i = 0; i < NREG; i++) write_reg(i, DW'(32'h0C00 + i));
        save_req_in = 1'b1;
        tick();
        save_req_in = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < NREG + 3; c++) begin
            check_ctrl("resave");
            if (done_out) done_cnt++;
            tick();
        end
        chk("resave_done", DW'(done_cnt), DW'(1));
        for (int i = 0; i < NREG; i++) begin
            rd_check("resave_hid", AW'(NREG + i), AW'(i));
            chk("resave_val", a_out, DW'(32'h0C00 + i));
            tick();
        end

        // Random traffic: writes, reads, forwarding hits and sporadic requests.
        for (int c = 0; c < 400; c++) begin
            d_in           = DW'($urandom);
            rw_in          = 1'($urandom_range(0, 1));
            wa_in          = AW'($urandom);
            save_req_in    = ($urandom_range(0, 19) == 0);
            restore_req_in = ($urandom_range(0, 19) == 0);
            rd_check("rand", AW'($urandom), (c % 4 == 0) ? wa_in : AW'($urandom));
            check_ctrl("rand");
            tick();
        end
        rw_in = 1'b0; save_req_in = 1'b0; restore_req_in = 1'b0;
        repeat (NREG + 3) tick();
        check_ctrl("final");
        for (int i = 0; i < NREG; i++) begin
            rd_check("final_rd", AW'(i), AW'(NREG + i));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
